frame_shadow_reader: RTL and testbench

- Sits between all pixel drawers (entrance, cars, player) and the VGA adapter.
- Consumes the drawers' plot/x/y/colour write stream and forwards it to the VGA adapter one cycle later.
- Keeps a shadow copy of every plotted pixel in on-chip RAM.
- Gives the collision logic a read port (request/valid) for looking up the colour at any (x, y). This is the read side of the pixel-write interface the drawers use.

---
 rtl/frame_shadow_reader.sv | 161 ++++++++++++++++
 tb/tb_frame_shadow_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_shadow_reader.sv
`default_nettype none
// ============================================================================
// Module   : frame_shadow_reader
// Purpose  : Forwards drawer pixel writes to the VGA adapter, keeps a shadow
//            frame in RAM and serves colour lookups for collision logic.
// Revision : 1.0 - initial release
// ============================================================================
module frame_shadow_reader #(
  parameter int unsigned WIDTH        = 160,
  parameter int unsigned HEIGHT       = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       plot_in,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic       clear,
  input  logic       rd_req,
  input  logic [7:0] rd_x,
  input  logic [6:0] rd_y,
  output logic       rd_valid,
  output logic [2:0] rd_colour,
  output logic       busy,
  output logic       vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour
);

  localparam int unsigned c_NPIX = WIDTH * HEIGHT;
  localparam int unsigned c_AW   = $clog2(c_NPIX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [c_AW-1:0]   r_addr;
  logic [7:0]        r_cx;
  logic [6:0]        r_cy;
  logic              w_last;
  logic              w_idle;
  logic              w_sweep;

  logic [2:0]        r_mem [c_NPIX];

  logic              w_wr_in_range;
  logic              w_do_write;
  logic [c_AW-1:0]   w_wr_addr;

  logic              w_rd_in_range;
  logic              w_do_read;
  logic [c_AW-1:0]   w_rd_addr;
  logic [c_AW-1:0]   w_rd_idx;

  assign w_idle  = (r_state == S_IDLE);
  assign w_sweep = (r_state == S_CLEAR);
  assign w_last  = (r_addr == c_AW'(c_NPIX - 1));

  // Linear addresses are formed at full RAM width so no row ever aliases.
  assign w_wr_in_range = (32'(x_in) < WIDTH) && (32'(y_in) < HEIGHT);
  assign w_wr_addr     = c_AW'(y_in) * c_AW'(WIDTH) + c_AW'(x_in);
  assign w_do_write    = w_idle && plot_in && w_wr_in_range;

  assign w_rd_in_range = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
  assign w_rd_addr     = c_AW'(rd_y) * c_AW'(WIDTH) + c_AW'(rd_x);
  assign w_rd_idx      = w_rd_in_range ? w_rd_addr : '0;
  assign w_do_read     = w_idle && rd_req;

  // Reset parks the FSM in CLEAR so the frame is blanked as soon as resetn rises.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (clear) w_state_next = S_CLEAR;
      S_CLEAR: if (w_last) w_state_next = S_IDLE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sweep position: linear address plus nested column/row counters.
  always_ff @(posedge clock) begin
    if (!resetn || !w_sweep || w_last) begin
      r_addr <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
    end else begin
      r_addr <= r_addr + 1'b1;
      if (32'(r_cx) == WIDTH - 1) begin
        r_cx <= '0;
        r_cy <= r_cy + 1'b1;
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      if (w_sweep) begin
        r_mem[r_addr] <= CLEAR_COLOUR;
      end else if (w_do_write) begin
        r_mem[w_wr_addr] <= colour_in;
      end
    end
  end

  // Read samples the array before this cycle's write lands (read-before-write).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_valid  <= 1'b0;
      rd_colour <= 3'b000;
    end else begin
      rd_valid <= w_do_read;
      if (w_do_read) begin
        rd_colour <= w_rd_in_range ? r_mem[w_rd_idx] : CLEAR_COLOUR;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'b000;
    end else begin
      busy <= w_sweep;
      if (w_sweep) begin
        vga_plot   <= 1'b1;
        vga_x      <= r_cx;
        vga_y      <= r_cy;
        vga_colour <= CLEAR_COLOUR;
      end else begin
        vga_plot <= w_do_write;
        if (w_do_write) begin
          vga_x      <= x_in;
          vga_y      <= y_in;
          vga_colour <= colour_in;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_shadow_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_shadow_reader
// Purpose  : Self-checking bench: vector table, read scoreboard, sweep checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_shadow_reader;

  localparam int c_W    = 160;
  localparam int c_H    = 120;
  localparam int c_NPIX = c_W * c_H;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       plot_in = 1'b0;
  logic [7:0] x_in = 8'd0;
  logic [6:0] y_in = 7'd0;
  logic [2:0] colour_in = 3'd0;
  logic       clear = 1'b0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_x = 8'd0;
  logic [6:0] rd_y = 7'd0;
  logic       rd_valid;
  logic [2:0] rd_colour;
  logic       busy;
  logic       vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int checks = 0;
  int errors = 0;

  logic [2:0] shadow [c_NPIX];
  logic [2:0] exp_q [$];

  frame_shadow_reader dut (
    .clock      (clock),
    .resetn     (resetn),
    .plot_in    (plot_in),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .clear      (clear),
    .rd_req     (rd_req),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_valid   (rd_valid),
    .rd_colour  (rd_colour),
    .busy       (busy),
    .vga_plot   (vga_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       p;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       rq;
    logic [7:0] rx;
    logic [6:0] ry;
    logic       ev;
    logic [7:0] evx;
    logic [6:0] evy;
    logic [2:0] evc;
  } vec_t;

  vec_t vecs [15];

  // Scoreboard consumer: every rd_valid pops one expected colour.
  always @(negedge clock) begin
    if (resetn && rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_valid=1 rd_colour=%0d, required no response", rd_colour);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (rd_colour !== e) begin
          errors++;
          $display("FAIL rd_colour: got %0d, required %0d", rd_colour, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] model_read(input logic [7:0] rx, input logic [6:0] ry);
    if (int'(rx) < c_W && int'(ry) < c_H) return shadow[int'(ry) * c_W + int'(rx)];
    return 3'b000;
  endfunction

  task automatic step(input logic p, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                      input logic rq, input logic [7:0] rx, input logic [6:0] ry, input logic clr,
                      input logic ev, input logic [7:0] evx, input logic [6:0] evy, input logic [2:0] evc,
                      input string tag);
    plot_in = p; x_in = x; y_in = y; colour_in = c;
    rd_req = rq; rd_x = rx; rd_y = ry; clear = clr;
    if (rq) exp_q.push_back(model_read(rx, ry));
    if (p && int'(x) < c_W && int'(y) < c_H) shadow[int'(y) * c_W + int'(x)] = c;
    tick();
    checks++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== {ev, evx, evy, evc}) begin
      errors++;
      $display("FAIL %s_vga: got plot=%0d x=%0d y=%0d c=%0d, required plot=%0d x=%0d y=%0d c=%0d",
               tag, vga_plot, vga_x, vga_y, vga_colour, ev, evx, evy, evc);
    end
    checks++;
    if (rd_valid !== rq) begin
      errors++;
      $display("FAIL %s_rd_valid: got %0d, required %0d", tag, rd_valid, rq);
    end
    plot_in = 1'b0; rd_req = 1'b0; clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({rd_valid, rd_colour, busy, vga_plot, vga_x, vga_y, vga_colour} !== 26'd0) begin
      errors++;
      $display("FAIL %s_outputs: got rd_valid=%0d rd_colour=%0d busy=%0d plot=%0d x=%0d y=%0d c=%0d, required all 0",
               tag, rd_valid, rd_colour, busy, vga_plot, vga_x, vga_y, vga_colour);
    end
  endtask

  // Follows one full sweep; releases any held plot/read inputs before the FSM returns to IDLE.
  task automatic check_sweep(input int max_wait, input string tag);
    int n, bad, w, ex, ey;
    n = 0; bad = 0; w = 0; ex = 0; ey = 0;
    while (busy !== 1'b1 && w < max_wait) begin
      tick();
      w++;
    end
    while (busy === 1'b1 && n < c_NPIX + 16) begin
      if (vga_plot !== 1'b1 || vga_x !== 8'(ex) || vga_y !== 7'(ey) || vga_colour !== 3'b000 || rd_valid !== 1'b0) begin
        if (bad == 0)
          $display("FAIL %s_pixel: at %0d got plot=%0d x=%0d y=%0d c=%0d rd_valid=%0d, required plot=1 x=%0d y=%0d c=0 rd_valid=0",
                   tag, n, vga_plot, vga_x, vga_y, vga_colour, rd_valid, ex, ey);
        bad++;
      end
      clear = (n == 100);
      if (n == c_NPIX - 1) begin
        plot_in = 1'b0;
        rd_req  = 1'b0;
      end
      n++;
      ex++;
      if (ex == c_W) begin
        ex = 0;
        ey++;
      end
      tick();
    end
    clear = 1'b0;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (n != c_NPIX) begin
      errors++;
      $display("FAIL %s_length: got %0d busy cycles, required %0d", tag, n, c_NPIX);
    end
    checks++;
    if (busy !== 1'b0 || vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: got busy=%0d plot=%0d, required busy=0 plot=0", tag, busy, vga_plot);
    end
    for (int i = 0; i < c_NPIX; i++) shadow[i] = 3'b000;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'd5,   7'd7,   3'd4, 1'b0, 8'd0,   7'd0,   1'b1, 8'd5,   7'd7,   3'd4};
    vecs[1]  = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 8'd0,   7'd0,   1'b0, 8'd5,   7'd7,   3'd4};
    vecs[2]  = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 8'd5,   7'd7,   1'b0, 8'd5,   7'd7,   3'd4};
    vecs[3]  = '{1'b1, 8'd10,  7'd10,  3'd2, 1'b1, 8'd10,  7'd10,  1'b1, 8'd10,  7'd10,  3'd2};
    vecs[4]  = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 8'd10,  7'd10,  1'b0, 8'd10,  7'd10,  3'd2};
    vecs[5]  = '{1'b1, 8'd160, 7'd5,   3'd7, 1'b0, 8'd0,   7'd0,   1'b0, 8'd10,  7'd10,  3'd2};
    vecs[6]  = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 8'd160, 7'd5,   1'b0, 8'd10,  7'd10,  3'd2};
    vecs[7]  = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 8'd0,   7'd120, 1'b0, 8'd10,  7'd10,  3'd2};
    vecs[8]  = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 8'd0,   7'd6,   1'b0, 8'd10,  7'd10,  3'd2};
    vecs[9]  = '{1'b1, 8'd159, 7'd119, 3'd3, 1'b1, 8'd5,   7'd7,   1'b1, 8'd159, 7'd119, 3'd3};
    vecs[10] = '{1'b1, 8'd0,   7'd0,   3'd5, 1'b1, 8'd159, 7'd119, 1'b1, 8'd0,   7'd0,   3'd5};
    vecs[11] = '{1'b1, 8'd3,   7'd3,   3'd6, 1'b1, 8'd0,   7'd0,   1'b1, 8'd3,   7'd3,   3'd6};
    vecs[12] = '{1'b1, 8'd255, 7'd127, 3'd7, 1'b0, 8'd0,   7'd0,   1'b0, 8'd3,   7'd3,   3'd6};
    vecs[13] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 8'd255, 7'd127, 1'b0, 8'd3,   7'd3,   3'd6};
    vecs[14] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 8'd3,   7'd3,   1'b0, 8'd3,   7'd3,   3'd6};
    for (int i = 0; i < c_NPIX; i++) shadow[i] = 3'b000;

    // Reset state, then the automatic power-on sweep.
    resetn = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();
    check_sweep(0, "initial_sweep");
    repeat (2) tick();

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].p, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].rq, vecs[i].rx, vecs[i].ry, 1'b0,
           vecs[i].ev, vecs[i].evx, vecs[i].evy, vecs[i].evc, $sformatf("vec%0d", i));
    end

    // rd_colour keeps the last returned value while idle.
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 8'd0, 7'd0, 1'b0, 1'b0, 8'd3, 7'd3, 3'd6, "hold");
    checks++;
    if (rd_colour !== 3'd6) begin
      errors++;
      $display("FAIL rd_hold: got %0d, required 6", rd_colour);
    end

    // clear together with a write and a read, then plot/read held high through the sweep.
    step(1'b1, 8'd20, 7'd20, 3'd7, 1'b1, 8'd3, 7'd3, 1'b1, 1'b1, 8'd20, 7'd20, 3'd7, "clear_start");
    plot_in = 1'b1; x_in = 8'd1; y_in = 7'd1; colour_in = 3'd7;
    rd_req = 1'b1; rd_x = 8'd3; rd_y = 7'd3;
    check_sweep(2, "clear_sweep");
    tick();
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd3, 7'd3, 1'b0, 1'b0, 8'd159, 7'd119, 3'd0, "after_clear_a");
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd20, 7'd20, 1'b0, 1'b0, 8'd159, 7'd119, 3'd0, "after_clear_b");

    // Reset in the middle of a sweep restarts it from pixel 0.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    begin
      int w, n, bad;
      w = 0; n = 0; bad = 0;
      while (busy !== 1'b1 && w < 4) begin
        tick();
        w++;
      end
      while (n < 5000) begin
        if (busy !== 1'b1) bad++;
        tick();
        n++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL midsweep_busy: got %0d cycles with busy=0, required 0", bad);
      end
    end
    resetn = 1'b0;
    repeat (2) tick();
    check_reset_outputs("midsweep_reset");
    resetn = 1'b1;
    tick();
    check_sweep(0, "restart_sweep");

    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_missing: got %0d reads without response, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
